mult_fu: RTL

Pipelined 32x32 RV32M multiplier functional unit in the execute stage. Accepts one issued MUL/MULH/MULHSU/MULHU operation per cycle from the reservation-station issue path. Computes the product over STAGES pipeline stages and presents the result with its ROB tag to the CDB arbiter. The result is held until the CDB acknowledges it, and backpressure stalls the whole pipeline.

---
 rtl/mult_fu.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mult_fu.sv
// mult_fu: pipelined RV32M multiplier functional unit (MUL/MULH/MULHSU/MULHU).
//
// Each operand is extended to 33 bits (sign or zero, depending on func) and then
// to 66 bits. The 66-bit product is accumulated over STAGES register stages.
// Each stage retires XLEN/STAGES multiplier bits by shift-add. The last stage is
// the output register that drives done/result/tag_out toward the CDB.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   squash         synchronous flush of every in-flight op, output included
//   start          issue valid (taken only when ready=1)
//   rs1, rs2       multiplicand, multiplier
//   func           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   tag_in         ROB tag of the issued op
//   ready          the unit can accept an issue this cycle
//   done           result/tag_out valid and waiting for ack
//   result         selected product half
//   tag_out        ROB tag of result
//   ack            CDB grant for the current result
//
// Handshake: an issue transfers at a rising edge where start=1, ready=1 and
// squash=0. A result transfers at a rising edge where done=1, ack=1 and
// squash=0. A stalled output (done=1, ack=0) freezes every stage, bubbles
// included. ready depends only on registered state and ack.
module mult_fu #(
  parameter int STAGES = 4,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             start,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [1:0]       func,
  input  logic [TAG_W-1:0] tag_in,
  output logic             ready,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  input  logic             ack
);

  localparam int PW = 2 * XLEN + 2;  // 33x33 product, mod 2^66
  localparam int CH = XLEN / STAGES; // multiplier bits retired per stage

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       func;
    logic [PW-1:0]    mcand;   // extended multiplicand
    logic [XLEN-1:0]  mplier;  // multiplier bits not yet retired, LSB first
    logic [PW-1:0]    psum;    // partial product so far
  } stage_t;

  stage_t stg_q [STAGES];
  stage_t stg_d [STAGES];

  logic          adv;
  logic          rs1_signed;
  logic          rs2_signed;
  logic [PW-1:0] mcand0;
  logic [PW-1:0] mc_hi;
  logic [PW-1:0] corr;

  // Add one chunk of the multiplier times the multiplicand, weighted by its position.
  function automatic logic [PW-1:0] retire(input logic [PW-1:0] psum,
                                           input logic [PW-1:0] mcand,
                                           input logic [CH-1:0] chunk,
                                           input int            sh);
    logic [PW-1:0] part;
    part = mcand * PW'(chunk);
    return psum + (part << sh);
  endfunction

  assign rs1_signed = (func == 2'b01) || (func == 2'b10);
  assign rs2_signed = (func == 2'b01);
  assign mcand0     = {{(PW-XLEN){rs1_signed & rs1[XLEN-1]}}, rs1};
  assign mc_hi      = mcand0 << XLEN;
  // Only the low XLEN multiplier bits are retired through the stages. A
  // negative signed rs2 weighs -2^XLEN on its upper part. That weight is
  // preloaded into the partial sum as -(mcand << XLEN).
  assign corr       = (rs2_signed && rs2[XLEN-1]) ? (PW'(0) - mc_hi) : '0;

  assign done    = stg_q[STAGES-1].valid;
  assign adv     = !done || ack;
  assign ready   = adv;
  assign tag_out = stg_q[STAGES-1].tag;
  assign result  = (stg_q[STAGES-1].func == 2'b00) ? stg_q[STAGES-1].psum[XLEN-1:0]
                                                   : stg_q[STAGES-1].psum[2*XLEN-1:XLEN];

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      stg_d[s] = stg_q[s];
    end
    if (adv) begin
      // Stage 0 captures the issue (or a bubble) and retires chunk 0 at once.
      stg_d[0].valid  = start;
      stg_d[0].tag    = tag_in;
      stg_d[0].func   = func;
      stg_d[0].mcand  = mcand0;
      stg_d[0].mplier = rs2 >> CH;
      stg_d[0].psum   = retire(corr, mcand0, rs2[CH-1:0], 0);
      for (int s = 1; s < STAGES; s++) begin
        stg_d[s]        = stg_q[s-1];
        stg_d[s].mplier = stg_q[s-1].mplier >> CH;
        stg_d[s].psum   = retire(stg_q[s-1].psum, stg_q[s-1].mcand,
                                 stg_q[s-1].mplier[CH-1:0], s * CH);
      end
    end
    if (squash) begin
      for (int s = 0; s < STAGES; s++) begin
        stg_d[s].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < STAGES; s++) begin
        stg_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        stg_q[s] <= stg_d[s];
      end
    end
  end

endmodule
